// File: rtl/uart_pkg.sv
// Shared UART constants: bit timing default, CPU register map, receive FSM encoding
// and status-word bit positions. The addresses are common to the transmit side.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;

    localparam logic [31:0] DATA_ADDR_DEFAULT = 32'h0000_7EF0;
    localparam logic [31:0] STAT_ADDR_DEFAULT = 32'h0000_7EF4;

    localparam int STAT_VALID_BIT = 0;
    localparam int STAT_FERR_BIT  = 1;
    localparam int STAT_OVR_BIT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, bit-timing FSM and LSB-first shift register.
// byte_done / byte_ferr pulse for one cycle during the stop-bit sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       byte_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          sync1, rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        byte_done = 1'b0;
        byte_ferr = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                if (!rx_s) state_n = ST_START;
            end
            ST_START: begin
                // Mid-bit recheck filters glitches shorter than half a bit.
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at mid stop bit so the next start edge is caught immediately.
                if (cnt == LAST) begin
                    cnt_n     = '0;
                    state_n   = ST_IDLE;
                    byte_done = rx_s;
                    byte_ferr = !rx_s;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign byte_data = shreg;

endmodule

// File: rtl/uart_rx_word.sv
// Packs four received bytes (first byte in [31:24]) into a word and exposes the
// word plus sticky status flags through a combinational CPU read port.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [31:0] DATA_ADDR    = DATA_ADDR_DEFAULT,
    parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        re,
    input  logic [31:0] address,
    output logic [31:0] rdata,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        overrun
);

    logic [7:0]  byte_data;
    logic        byte_done, byte_ferr;
    logic [1:0]  byte_idx;
    logic [23:0] partial;
    logic [31:0] data_reg;
    logic        data_rd, stat_rd, word_done, load;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .byte_ferr (byte_ferr)
    );

    assign data_rd   = re && (address == DATA_ADDR);
    assign stat_rd   = re && (address == STAT_ADDR);
    assign word_done = byte_done && (byte_idx == 2'd3);
    // A read in the completion cycle frees the register, so the new word may load.
    assign load      = word_done && (!rx_valid || data_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx  <= '0;
            partial   <= '0;
            data_reg  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (byte_ferr) begin
                byte_idx <= '0;
            end else if (byte_done) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    partial[23:16] <= byte_data;
                    2'd1:    partial[15:8]  <= byte_data;
                    2'd2:    partial[7:0]   <= byte_data;
                    default: partial        <= partial;
                endcase
            end

            if (load)         data_reg <= {partial, byte_data};

            if (load)         rx_valid <= 1'b1;
            else if (data_rd) rx_valid <= 1'b0;

            if (byte_ferr)    frame_err <= 1'b1;
            else if (stat_rd) frame_err <= 1'b0;

            if (word_done && !load) overrun <= 1'b1;
            else if (stat_rd)       overrun <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (data_rd) begin
            rdata = data_reg;
        end else if (stat_rd) begin
            rdata[STAT_VALID_BIT] = rx_valid;
            rdata[STAT_FERR_BIT]  = frame_err;
            rdata[STAT_OVR_BIT]   = overrun;
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit; inputs driven and outputs
// sampled on the falling edge.
module tb_uart_rx_word;

    localparam int CPB = 16;
    localparam logic [31:0] DADDR = 32'h0000_7EF0;
    localparam logic [31:0] SADDR = 32'h0000_7EF4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        re = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] rdata;
    logic        rx_valid, frame_err, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_word #(.CLKS_PER_BIT(CPB), .DATA_ADDR(DADDR), .STAT_ADDR(SADDR)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .re        (re),
        .address   (address),
        .rdata     (rdata),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic [2:0] exp);
        check(tag, {29'b0, overrun, frame_err, rx_valid}, {29'b0, exp});
    endtask

    // Called on a falling edge; returns 'tail' falling edges after the stop bit starts.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int tail);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (tail) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1, CPB);
        send_byte(w[23:16], 1'b1, CPB);
        send_byte(w[15:8],  1'b1, CPB);
        send_byte(w[7:0],   1'b1, CPB);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        re = 1'b1;
        address = a;
        #1 d = rdata;
        @(negedge clk);
        re = 1'b0;
        address = '0;
    endtask

    logic [31:0] v;

    initial begin
        repeat (3) @(negedge clk);
        flags("reset_flags", 3'b000);
        check("rdata_re_low", rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        rd(DADDR, v); check("reset_data", v, 32'h0);
        rd(SADDR, v); check("reset_stat", v, 32'h0);

        // DEADBEEF with exact rx_valid latency on the 4th byte
        send_byte(8'hDE, 1'b1, CPB);
        send_byte(8'hAD, 1'b1, CPB);
        send_byte(8'hBE, 1'b1, CPB);
        send_byte(8'hEF, 1'b1, 10);
        flags("valid_before_edge", 3'b000);
        @(negedge clk);
        flags("valid_after_edge", 3'b001);
        repeat (5) @(negedge clk);
        rd(DADDR, v); check("word_deadbeef", v, 32'hDEAD_BEEF);
        flags("valid_cleared", 3'b000);
        rd(32'h0000_7EF8, v); check("unmapped_read", v, 32'h0);

        // short glitch on idle line
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        flags("glitch_no_flags", 3'b000);
        send_word(32'hC0FF_EE42);
        rd(DADDR, v); check("word_after_glitch", v, 32'hC0FF_EE42);

        // framing error abandons the partial word
        send_byte(8'h11, 1'b1, CPB);
        send_byte(8'h22, 1'b0, CPB);
        repeat (2 * CPB) @(negedge clk);
        flags("ferr_set", 3'b010);
        send_word(32'h3344_5566);
        rd(SADDR, v); check("stat_ferr_valid", v, 32'h3);
        flags("ferr_cleared", 3'b001);
        rd(DADDR, v); check("word_after_ferr", v, 32'h3344_5566);

        // overrun: second word dropped
        send_word(32'h0102_0304);
        send_word(32'hA5A5_5A5A);
        flags("overrun_set", 3'b101);
        rd(SADDR, v); check("stat_overrun", v, 32'h5);
        flags("overrun_cleared", 3'b001);
        rd(DADDR, v); check("word_kept_first", v, 32'h0102_0304);

        // DATA read in the completion cycle of word 2
        send_word(32'h1234_5678);
        send_byte(8'h9A, 1'b1, CPB);
        send_byte(8'hBC, 1'b1, CPB);
        send_byte(8'hDE, 1'b1, CPB);
        send_byte(8'hF0, 1'b1, 10);
        re = 1'b1;
        address = DADDR;
        #1 check("coincident_read_old", rdata, 32'h1234_5678);
        @(negedge clk);
        re = 1'b0;
        address = '0;
        flags("coincident_flags", 3'b001);
        repeat (5) @(negedge clk);
        rd(DADDR, v); check("coincident_word2", v, 32'h9ABC_DEF0);

        // reset after two bytes
        send_byte(8'hFF, 1'b1, CPB);
        send_byte(8'hEE, 1'b1, CPB);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h5A, 1'b1, CPB);
        send_byte(8'h69, 1'b1, CPB);
        send_byte(8'h96, 1'b1, CPB);
        flags("reset_partial_flags", 3'b000);
        send_byte(8'hA5, 1'b1, CPB);
        flags("reset_word_valid", 3'b001);
        rd(DADDR, v); check("word_after_reset", v, 32'h5A69_96A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Serial receiver that is the far-end counterpart of the UART transmit path. It samples an 8N1 line and deserializes bytes LSB-first. It packs four consecutive bytes into a 32-bit word, first byte into [31:24], matching the transmit byte order. It exposes the word and status flags to the CPU through a memory-mapped read port.

## Interface
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be ≥ 4
- DATA_ADDR, 32'h0000_7EF0, read address of the received word
- STAT_ADDR, 32'h0000_7EF4, read address of the status word
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high; clock clk
- rx  in  1  asynchronous serial input, idle high
- re  in  1  CPU read strobe, one cycle per access
- address  in  32  CPU read address
- rdata  out  32  read data, combinational; 0 when `re` is low or the address matches neither register
- rx_valid  out  1  unread word held in data register
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: completed word dropped because `rx_valid` was still set

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1; all sampling uses the synchronized bit.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized `rx` = 0; bit counter cleared.
  - START: sample at CLKS_PER_BIT/2 (integer division). If low, go to DATA with counter reset. If high, it is a false start: return to IDLE with no flags set.
  - DATA: sample every CLKS_PER_BIT cycles into shift bit 7, shifting right. After 8 samples, go to STOP.
  - STOP: sample after CLKS_PER_BIT. Then return to IDLE in the same cycle; no wait for the full stop bit, which allows resynchronisation on the next start edge.
- Stop sample = 1: byte accepted; byte_idx 0..3 selects word lane [31:24], [23:16], [15:8], [7:0] in that order.
- Stop sample = 0: byte discarded, `frame_err` set, byte_idx forced to 0 so the partial word is abandoned.
- byte_idx = 3 accepted, `rx_valid` = 0: assembled word copied to the data register, `rx_valid` set, byte_idx wraps to 0.
- byte_idx = 3 accepted, `rx_valid` = 1: word dropped, data register unchanged, `overrun` set, byte_idx wraps to 0.
- Read of DATA_ADDR: returns the data register and clears `rx_valid` at the next clock edge.
- Read of STAT_ADDR: returns {29'b0, overrun, frame_err, rx_valid}. Clears `frame_err` and `overrun` at the next edge.
- Simultaneous events:
  - DATA read in the same cycle a word completes: new word loaded, `rx_valid` stays 1, no overrun.
  - STAT read in the same cycle a flag sets: set wins, so the flag stays 1.

## Timing
- Reset values: FSM IDLE; byte_idx 0; data register 0; `rx_valid`, `frame_err`, `overrun` 0; synchronizer 1.
- Reset mid-frame aborts the frame; the partial word is lost.
- Start edge on pin -> first START sample: 2 sync cycles + CLKS_PER_BIT/2.
- Data bit k is sampled at (k+1)·CLKS_PER_BIT after the start-confirm sample, k = 0..7; stop bit at 9·CLKS_PER_BIT.
- `rx_valid` rises on the edge after the 4th stop sample: 1 cycle latency from stop sample.
- Back-to-back frames with zero idle gap are received without loss.

## Structure
- Shared package uart_pkg holds:
  - default CLKS_PER_BIT
  - DATA_ADDR and STAT_ADDR constants, shared with the transmit-side address constant
  - bit FSM state encoding
  - status bit positions
- One sub-module, uart_rx_byte: synchronizer, bit FSM and shift register, with outputs byte_data[7:0], byte_done and byte_ferr as 1-cycle strobes.
- uart_rx_word keeps the word assembly, flags and read mux.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- Send bytes 0xDE, 0xAD, 0xBE, 0xEF -> `rx_valid` = 1 one cycle after 4th stop sample; DATA read returns 32'hDEADBEEF; `rx_valid` = 0 next cycle.
- Glitch low for 4 cycles on idle line -> FSM back to IDLE; no flags; next valid 4-byte frame is received correctly.
- Bytes 0x11, 0x22 (stop bit 0), then 0x33, 0x44, 0x55, 0x66 -> `frame_err` = 1; word = 32'h33445566; STAT read returns 3'b011 and then `frame_err` = 0.
- Two full words with no DATA read in between -> `overrun` = 1; data register keeps the first word.
- DATA read issued in the exact cycle word 2 completes -> `rx_valid` stays 1, `overrun` = 0, next DATA read returns word 2.
- Assert reset after 2 bytes, then send 4 fresh bytes -> word contains only the fresh 4 bytes; all flags 0 before completion.
